// File: rtl/cart_mem_arbiter.sv
// Shares the SDRAM cartridge-ROM port between the two cart mapper paths and the ROM loader.
// One transaction at a time: loader first, then round-robin between the carts.
module cart_mem_arbiter #(
    parameter int ADDR_W  = 25,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] rom_base0,
    input  logic [ADDR_W-1:0] rom_base1,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [7:0]        ld_data,
    output logic              ld_ack,

    input  logic              c0_req,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic              c0_unmaped,
    output logic              c0_ack,
    output logic [7:0]        c0_data,

    input  logic              c1_req,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic              c1_unmaped,
    output logic              c1_ack,
    output logic [7:0]        c1_data,

    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wr,
    output logic [7:0]        mem_din,
    input  logic              mem_ack,
    input  logic [7:0]        mem_dout,

    output logic              busy,
    output logic              timeout_err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SRC_LD, SRC_C0, SRC_C1} src_t;

    state_t            state;
    state_t            state_nxt;
    src_t              src;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;

    logic              grant_ld;
    logic              grant_c0;
    logic              grant_c1;
    logic              grant_any;
    logic              grant_unmapped;
    logic              mem_done;
    logic              timeout_hit;
    logic [ADDR_W-1:0] c0_abs;
    logic [ADDR_W-1:0] c1_abs;

    // Base + offset deliberately wraps inside the ADDR_W-bit space.
    assign c0_abs = rom_base0 + c0_addr;
    assign c1_abs = rom_base1 + c1_addr;

    // last_grant holds the index of the cart served most recently.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        grant_ld = ld_req;
        grant_c0 = 1'b0;
        grant_c1 = 1'b0;
        if (!ld_req) begin
            if (c0_req && c1_req) begin
                grant_c0 = last_grant;
                grant_c1 = !last_grant;
            end else begin
                grant_c0 = c0_req;
                grant_c1 = c1_req;
            end
        end
    end

    assign grant_any      = grant_ld | grant_c0 | grant_c1;
    assign grant_unmapped = (grant_c0 & c0_unmaped) | (grant_c1 & c1_unmaped);
    assign mem_done       = ((state == ISSUE) || (state == WAIT)) && mem_ack;
    assign timeout_hit    = (state == WAIT) && !mem_ack && (wait_cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = grant_unmapped ? DONE : ISSUE;
                end
            end
            ISSUE:   state_nxt = mem_ack ? DONE : WAIT;
            WAIT: begin
                if (mem_ack || timeout_hit) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        mem_req = (state == ISSUE);
        ld_ack  = (state == DONE) && (src == SRC_LD);
        c0_ack  = (state == DONE) && (src == SRC_C0);
        c1_ack  = (state == DONE) && (src == SRC_C1);
    end

    // Grant capture, wait counter and read-data return.
    always_ff @(posedge clk) begin
        if (!reset) begin
            src         <= SRC_LD;
            last_grant  <= 1'b1;
            wait_cnt    <= '0;
            mem_addr    <= '0;
            mem_wr      <= 1'b0;
            mem_din     <= 8'h00;
            c0_data     <= 8'h00;
            c1_data     <= 8'h00;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        if (grant_ld) begin
                            src <= SRC_LD;
                        end else if (grant_c0) begin
                            src <= SRC_C0;
                        end else begin
                            src <= SRC_C1;
                        end

                        if (grant_c0 || grant_c1) begin
                            last_grant <= grant_c1;
                        end

                        if (grant_ld) begin
                            mem_addr <= ld_addr;
                            mem_wr   <= 1'b1;
                            mem_din  <= ld_data;
                        end else if (!grant_unmapped) begin
                            mem_addr <= grant_c0 ? c0_abs : c1_abs;
                            mem_wr   <= 1'b0;
                            mem_din  <= 8'h00;
                        end

                        // Unmapped reads never touch memory and float high.
                        if (grant_c0 && c0_unmaped) begin
                            c0_data <= 8'hFF;
                        end
                        if (grant_c1 && c1_unmaped) begin
                            c1_data <= 8'hFF;
                        end
                    end
                end
                ISSUE:   wait_cnt <= '0;
                WAIT:    wait_cnt <= wait_cnt + CNT_W'(1);
                default: ;
            endcase

            if (mem_done || timeout_hit) begin
                if (src == SRC_C0) begin
                    c0_data <= mem_done ? mem_dout : 8'hFF;
                end
                if (src == SRC_C1) begin
                    c1_data <= mem_done ? mem_dout : 8'hFF;
                end
            end

            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cart_mem_arbiter.sv
// Directed self-checking bench for cart_mem_arbiter: latency, arbitration order,
// unmapped reads, address wrap, timeout and mid-transaction reset.
module tb_cart_mem_arbiter;

    localparam int ADDR_W = 25;

    logic              clk;
    logic              reset;
    logic [ADDR_W-1:0] rom_base0;
    logic [ADDR_W-1:0] rom_base1;
    logic              ld_req;
    logic [ADDR_W-1:0] ld_addr;
    logic [7:0]        ld_data;
    logic              ld_ack;
    logic              c0_req;
    logic [ADDR_W-1:0] c0_addr;
    logic              c0_unmaped;
    logic              c0_ack;
    logic [7:0]        c0_data;
    logic              c1_req;
    logic [ADDR_W-1:0] c1_addr;
    logic              c1_unmaped;
    logic              c1_ack;
    logic [7:0]        c1_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr;
    logic [7:0]        mem_din;
    logic              mem_ack;
    logic [7:0]        mem_dout;
    logic              busy;
    logic              timeout_err;

    cart_mem_arbiter #(.ADDR_W(ADDR_W), .TIMEOUT(255)) dut (
        .clk         (clk),
        .reset       (reset),
        .rom_base0   (rom_base0),
        .rom_base1   (rom_base1),
        .ld_req      (ld_req),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .ld_ack      (ld_ack),
        .c0_req      (c0_req),
        .c0_addr     (c0_addr),
        .c0_unmaped  (c0_unmaped),
        .c0_ack      (c0_ack),
        .c0_data     (c0_data),
        .c1_req      (c1_req),
        .c1_addr     (c1_addr),
        .c1_unmaped  (c1_unmaped),
        .c1_ack      (c1_ack),
        .c1_data     (c1_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wr      (mem_wr),
        .mem_din     (mem_din),
        .mem_ack     (mem_ack),
        .mem_dout    (mem_dout),
        .busy        (busy),
        .timeout_err (timeout_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int                tests = 0;
    int                fails = 0;
    int                who;
    int                lat;
    int                req_cnt;
    int                c0_left;
    int                c1_left;
    logic [ADDR_W-1:0] cap_addr;
    logic              cap_wr;
    logic [7:0]        cap_din;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {8'h00, ld_ack, c0_ack, c0_data, c1_ack, c1_data, mem_req,
                mem_addr, mem_wr, mem_din, busy, timeout_err};
    endfunction

    // Runs until any ack (bounded). Answers mem_req 'delay' cycles later; delay < 0 never answers.
    // lat counts clock edges from the request-sampling edge to the ack cycle.
    task automatic run_txn(input int delay, input logic [7:0] dout);
        int since = -1;
        bit done  = 1'b0;
        who     = -1;
        lat     = 0;
        req_cnt = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            tick();
            lat     = i + 1;
            mem_ack = 1'b0;
            if (mem_req) begin
                req_cnt++;
                cap_addr = mem_addr;
                cap_wr   = mem_wr;
                cap_din  = mem_din;
                since    = 0;
            end
            if (ld_ack || c0_ack || c1_ack) begin
                who  = ld_ack ? 2 : (c0_ack ? 0 : 1);
                done = 1'b1;
            end else if (since >= 0) begin
                if (delay >= 0 && since == delay) begin
                    mem_ack  = 1'b1;
                    mem_dout = dout;
                end
                since++;
            end
        end
    endtask

    initial begin
        reset      = 1'b0;
        rom_base0  = 25'h0010000;
        rom_base1  = 25'h1FFF000;
        ld_req     = 1'b0;
        ld_addr    = '0;
        ld_data    = 8'h00;
        c0_req     = 1'b1;
        c0_addr    = 25'h0000001;
        c0_unmaped = 1'b0;
        c1_req     = 1'b0;
        c1_addr    = '0;
        c1_unmaped = 1'b0;
        mem_ack    = 1'b0;
        mem_dout   = 8'h00;

        // Reset holds everything at zero even with a request pending.
        tick();
        tick();
        check("reset_outs", outs(), 64'h0);
        c0_req = 1'b0;
        reset  = 1'b1;
        tick();

        // Cart 0 read, memory answers 3 cycles after mem_req.
        c0_addr = 25'h0002345;
        c0_req  = 1'b1;
        run_txn(3, 8'h5A);
        check("c0_who", 64'(who), 64'd0);
        check("c0_lat", 64'(lat), 64'd5);
        check("c0_req_cnt", 64'(req_cnt), 64'd1);
        check("c0_addr", 64'(cap_addr), 64'h0012345);
        check("c0_wr", 64'(cap_wr), 64'h0);
        check("c0_data", 64'(c0_data), 64'h5A);
        check("c0_addr_held", 64'(mem_addr), 64'h0012345);
        c0_req = 1'b0;
        tick();
        check("c0_idle_busy", 64'(busy), 64'h0);
        check("c0_ack_gone", 64'(c0_ack), 64'h0);
        check("c0_data_hold", 64'(c0_data), 64'h5A);

        // Minimum latency: mem_ack at T+2 gives ack at T+3.
        c0_addr = 25'h0000010;
        c0_req  = 1'b1;
        run_txn(1, 8'h11);
        check("min_lat", 64'(lat), 64'd3);
        check("min_data", 64'(c0_data), 64'h11);
        c0_req = 1'b0;
        tick();

        // mem_ack during ISSUE is accepted.
        c1_addr = 25'h0000005;
        c1_req  = 1'b1;
        run_txn(0, 8'h22);
        check("issue_ack_who", 64'(who), 64'd1);
        check("issue_ack_lat", 64'(lat), 64'd2);
        check("issue_ack_addr", 64'(cap_addr), 64'h1FFF005);
        check("issue_ack_data", 64'(c1_data), 64'h22);
        c1_req = 1'b0;
        tick();

        // Loader beats both carts; then the carts alternate starting with cart 0.
        ld_addr = 25'h00ABCDE;
        ld_data = 8'h3C;
        ld_req  = 1'b1;
        c0_req  = 1'b1;
        c1_req  = 1'b1;
        run_txn(1, 8'h00);
        check("ld_first", 64'(who), 64'd2);
        check("ld_wr", 64'(cap_wr), 64'h1);
        check("ld_din", 64'(cap_din), 64'h3C);
        check("ld_addr", 64'(cap_addr), 64'h00ABCDE);
        ld_req  = 1'b0;
        c0_left = 4;
        c1_left = 4;
        for (int k = 0; k < 8; k++) begin
            run_txn(1, 8'(8'h40 + k));
            check($sformatf("rr_grant%0d", k), 64'(who), 64'(k % 2));
            check($sformatf("rr_data%0d", k), 64'(who == 0 ? c0_data : c1_data), 64'(8'(8'h40 + k)));
            if (who == 0) begin
                c0_left--;
                c0_req = (c0_left > 0);
            end else begin
                c1_left--;
                c1_req = (c1_left > 0);
            end
        end
        c0_req = 1'b0;
        c1_req = 1'b0;
        tick();

        // Unmapped cart 1 access: ack next cycle, 0xFF, no memory command.
        c1_unmaped = 1'b1;
        c1_req     = 1'b1;
        run_txn(1, 8'h00);
        check("unmap_who", 64'(who), 64'd1);
        check("unmap_lat", 64'(lat), 64'd1);
        check("unmap_no_mem_req", 64'(req_cnt), 64'd0);
        check("unmap_data", 64'(c1_data), 64'hFF);
        c1_req     = 1'b0;
        c1_unmaped = 1'b0;
        tick();

        // Base + offset wraps within 25 bits.
        c1_addr = 25'h0002000;
        c1_req  = 1'b1;
        run_txn(2, 8'h77);
        check("wrap_addr", 64'(cap_addr), 64'h0001000);
        check("wrap_data", 64'(c1_data), 64'h77);
        check("terr_before", 64'(timeout_err), 64'h0);
        c1_req = 1'b0;
        tick();

        // Memory never answers: forced completion after the counter hits 255.
        c0_addr = 25'h0000001;
        c0_req  = 1'b1;
        run_txn(-1, 8'h00);
        check("to_who", 64'(who), 64'd0);
        check("to_lat", 64'(lat), 64'd258);
        check("to_data", 64'(c0_data), 64'hFF);
        check("to_err", 64'(timeout_err), 64'h1);
        c0_req = 1'b0;
        tick();
        c0_req = 1'b1;
        run_txn(2, 8'h99);
        check("to_after_data", 64'(c0_data), 64'h99);
        check("to_err_sticky", 64'(timeout_err), 64'h1);
        c0_req = 1'b0;
        tick();

        // Reset during WAIT, then a stray mem_ack in IDLE.
        c0_addr = 25'h0000003;
        c0_req  = 1'b1;
        tick();
        tick();
        tick();
        check("rst_busy_before", 64'(busy), 64'h1);
        reset  = 1'b0;
        c0_req = 1'b0;
        tick();
        check("rst_mid_outs", outs(), 64'h0);
        reset    = 1'b1;
        mem_ack  = 1'b1;
        mem_dout = 8'hEE;
        tick();
        mem_ack = 1'b0;
        check("late_ack_outs", outs(), 64'h0);
        tick();
        check("late_ack_outs2", outs(), 64'h0);
        c0_addr = 25'h0002345;
        c0_req  = 1'b1;
        run_txn(3, 8'hA5);
        check("post_rst_who", 64'(who), 64'd0);
        check("post_rst_lat", 64'(lat), 64'd5);
        check("post_rst_addr", 64'(cap_addr), 64'h0012345);
        check("post_rst_data", 64'(c0_data), 64'hA5);
        c0_req = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cart_mem_arbiter.md
Name: cart_mem_arbiter

Overview:
- Shares the single SDRAM cartridge-ROM port between the two cartridge mapper paths (cart 0, cart 1) and the ROM image loader.
- Each mapper presents a mapped 25-bit ROM offset plus an unmapped flag. The arbiter adds the per-cart base address, sequences one memory transaction at a time, and returns read data with a one-cycle ack.
- Sits between the slot/mapper logic and the SDRAM controller.

Parameters:
- ADDR_W, 25, width of ROM offsets, base addresses and memory address.
- TIMEOUT, 255, maximum cycles spent in WAIT before a transaction is forcibly completed.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset: 0 = reset, sampled on the rising edge of clk.
- rom_base0  in  ADDR_W  SDRAM base of cart 0 image.
- rom_base1  in  ADDR_W  SDRAM base of cart 1 image.
- ld_req  in  1  loader write request; level, held until ld_ack.
- ld_addr  in  ADDR_W  absolute SDRAM write address.
- ld_data  in  8  loader write data.
- ld_ack  out  1  one-cycle loader completion pulse.
- c0_req  in  1  cart 0 read request; level, held until c0_ack.
- c0_addr  in  ADDR_W  cart 0 mapped ROM offset.
- c0_unmaped  in  1  cart 0 access is unmapped.
- c0_ack  out  1  one-cycle cart 0 completion pulse.
- c0_data  out  8  cart 0 read data, valid while c0_ack is high.
- c1_req, c1_addr, c1_unmaped, c1_ack, c1_data: same as cart 0, for cart 1.
- mem_req  out  1  one-cycle memory command strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wr  out  1  1 = write, 0 = read.
- mem_din  out  8  memory write data.
- mem_ack  in  1  memory completion pulse.
- mem_dout  in  8  memory read data, valid with mem_ack.
- busy  out  1  high in any state other than IDLE.
- timeout_err  out  1  sticky flag, set on any timeout.

Behaviour:
- Reset (reset == 0): state goes to IDLE; all outputs are 0, including c0_data, c1_data, mem_addr, mem_din and timeout_err; round-robin pointer last_grant = 1, so cart 0 wins first.
- Reset mid-transaction: the transaction is abandoned and no ack is issued. A mem_ack arriving in IDLE is ignored.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE, with a request pending at cycle T:
  - Priority: ld_req first. Then between c0_req and c1_req, round-robin: when both are pending, grant the cart other than last_grant. A single pending cart always wins.
  - On grant, latch requester id, mem_wr and mem_din (= ld_data for loader).
  - Loader address: ld_addr.
  - Cart address: rom_baseN + cN_addr, truncated to ADDR_W bits (wrap-around, no carry out).
  - Update last_grant on any cart grant.
- Unmapped cart grant (cN_unmaped = 1 at T): go IDLE -> DONE with read data 8'hFF. No mem_req. cN_ack is high at T+1.
- Mapped grant: go to ISSUE at T+1. mem_req = 1 for exactly one cycle (T+1); mem_addr, mem_wr and mem_din are held stable from T+1 until DONE exits.
- WAIT (from T+2):
  - Cycle counter starts at 0 and increments each cycle.
  - On mem_ack: latch mem_dout and go to DONE.
  - If the counter reaches TIMEOUT with no mem_ack: read data = 8'hFF, set timeout_err, go to DONE.
  - A mem_ack during ISSUE is accepted identically.
- DONE: exactly one of ld_ack / c0_ack / c1_ack is high for one cycle, and the cN_data of the granted cart is driven; then go to IDLE. Minimum mapped latency: mem_ack at T+2 gives ack at T+3.
- cN_data holds its last value outside the ack cycle. Requesters drop req at the edge where ack is sampled. A new request is evaluated in the first IDLE cycle after DONE, so back-to-back grants are 1 idle cycle apart.
- Requests asserted while busy wait; they are never dropped or reordered except per the priority rules above.
- busy = (state != IDLE).
- timeout_err clears only on reset.

Test Plan:
- Cart 0 read: rom_base0=0x010000, c0_addr=0x2345, mem_ack returned 3 cycles after mem_req with mem_dout=0x5A -> one mem_req with mem_addr=0x012345, mem_wr=0; c0_ack one cycle later with c0_data=0x5A.
- c0_req and c1_req asserted together, each re-asserted 4 times -> grant order 0,1,0,1,0,1,0,1. With ld_req also pending -> loader is served first; ld write uses mem_wr=1, mem_din=ld_data, mem_addr=ld_addr.
- c1_unmaped=1 -> c1_ack at T+1, c1_data=0xFF, mem_req never asserted.
- mem_ack withheld, TIMEOUT=255 -> c0_ack after the WAIT counter reaches 255 with c0_data=0xFF; timeout_err=1 and stays 1 through later good transfers.
- Wrap: rom_base1=0x1FFF000, c1_addr=0x002000 -> mem_addr=0x0001000.
- reset pulled low during WAIT, then released and a late mem_ack delivered -> no ack pulse, all outputs 0, state IDLE; the next c0_req completes normally.
